// File: rtl/alarm_fan_ctrl_pkg.sv
// Shared encodings and constants for the alarm/fan actuator stage.
// Severity states are ordered so that a numeric max() picks the worse condition.
package alarm_fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_ALERTA  = 2'b01,
        ST_PELIGRO = 2'b10,
        ST_EMERG   = 2'b11
    } state_t;

    localparam logic [4:0] DUTY_ALERT_MIN = 5'd12;
    localparam logic [4:0] DUTY_FULL      = 5'd16;
    localparam int         PWM_STEPS      = 16;

endpackage

// File: rtl/alarm_fan_ctrl_pwm_gen.sv
// Fan PWM generator: prescaler, 16-step phase counter and a duty register that
// only reloads at period boundaries so no period is ever truncated.
module pwm_gen
    import alarm_fan_ctrl_pkg::*;
#(
    parameter int PRESC_DIV = 6250
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [4:0] duty,
    output logic       pwm
);

    localparam int             PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(PRESC_DIV - 1);
    localparam logic [3:0]     PHASE_LAST = 4'(PWM_STEPS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    phase_q, phase_d;
    logic [4:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        phase_d = tick ? phase_q + 4'd1 : phase_q;
        duty_d  = (tick && phase_q == PHASE_LAST) ? duty : duty_q;
        // Compare against next-state values so the registered output matches phase < duty.
        pwm_d   = ({1'b0, phase_d} < duty_d);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            presc_q <= '0;
            phase_q <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/alarm_fan_ctrl.sv
// Alarm severity FSM with Greset-only de-escalation, fan duty mapping and
// buzzer blink; the PWM waveform itself is produced by pwm_gen.
module alarm_fan_ctrl
    import alarm_fan_ctrl_pkg::*;
#(
    parameter int PRESC_DIV = 6250,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Temps,
    input  logic       Gas,
    input  logic       Peligro,
    input  logic       Alerta,
    input  logic       Greset,
    output logic       fan_pwm,
    output logic       buzzer,
    output logic       led_alerta,
    output logic       led_peligro,
    output logic [1:0] state
);

    localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    state_t        state_q, state_d, flag_lvl;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;
    logic          buzzer_q, buzzer_d;
    logic          led_al_q, led_pe_q;
    logic [4:0]    target_duty;

    always_comb begin
        flag_lvl = ST_NORMAL;
        if (Gas)
            flag_lvl = ST_EMERG;
        else if (Peligro)
            flag_lvl = ST_PELIGRO;
        else if (Alerta)
            flag_lvl = ST_ALERTA;

        // Without Greset the state only escalates; with it, it follows the live flags.
        state_d = state_q;
        if (Greset || flag_lvl > state_q)
            state_d = flag_lvl;

        bcnt_d  = '0;
        blink_d = 1'b0;
        if (state_d == ST_PELIGRO && state_q == ST_PELIGRO) begin
            if (bcnt_q == BLINK_MAX) begin
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
                blink_d = blink_q;
            end
        end

        buzzer_d = (state_d == ST_EMERG) || (state_d == ST_PELIGRO && !blink_d);

        case (state_q)
            ST_NORMAL: target_duty = {1'b0, Temps};
            ST_ALERTA: target_duty = ({1'b0, Temps} > DUTY_ALERT_MIN) ? {1'b0, Temps} : DUTY_ALERT_MIN;
            default:   target_duty = DUTY_FULL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= ST_NORMAL;
            bcnt_q   <= '0;
            blink_q  <= 1'b0;
            buzzer_q <= 1'b0;
            led_al_q <= 1'b0;
            led_pe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
            buzzer_q <= buzzer_d;
            led_al_q <= (state_d >= ST_ALERTA);
            led_pe_q <= (state_d >= ST_PELIGRO);
        end
    end

    pwm_gen #(.PRESC_DIV(PRESC_DIV)) u_pwm_gen (
        .CLK   (CLK),
        .reset (reset),
        .duty  (target_duty),
        .pwm   (fan_pwm)
    );

    assign buzzer      = buzzer_q;
    assign led_alerta  = led_al_q;
    assign led_peligro = led_pe_q;
    assign state       = state_q;

endmodule

// File: tb/tb_alarm_fan_ctrl.sv
// Directed plus randomized bench for alarm_fan_ctrl, checked every cycle against
// a cycle-count based reference model of severity, PWM period and blink timing.
module tb_alarm_fan_ctrl;

    logic       CLK = 1'b0;
    logic       reset, Gas, Peligro, Alerta, Greset;
    logic [3:0] Temps;
    logic       fan_pwm, buzzer, led_alerta, led_peligro;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model: severity as an integer, PWM as cycles since reset mod 16,
    // blink as cycles since entering PELIGRO.
    int mState, mDuty, mCyc, mPel;
    int mPwm, mBuzz;

    alarm_fan_ctrl #(.PRESC_DIV(1), .BLINK_DIV(4)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .Temps       (Temps),
        .Gas         (Gas),
        .Peligro     (Peligro),
        .Alerta      (Alerta),
        .Greset      (Greset),
        .fan_pwm     (fan_pwm),
        .buzzer      (buzzer),
        .led_alerta  (led_alerta),
        .led_peligro (led_peligro),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelStep();
        int flag, target, nxt;
        if (!reset) begin
            mState = 0; mDuty = 0; mCyc = 0; mPel = 0;
        end else begin
            flag = Gas ? 3 : Peligro ? 2 : Alerta ? 1 : 0;
            if (mState == 0)      target = Temps;
            else if (mState == 1) target = (Temps > 12) ? int'(Temps) : 12;
            else                  target = 16;
            if (mCyc % 16 == 15) mDuty = target;
            mCyc++;
            nxt = Greset ? flag : ((flag > mState) ? flag : mState);
            if (nxt == 2) mPel = (mState == 2) ? mPel + 1 : 0;
            mState = nxt;
        end
        mPwm  = (reset && (mCyc % 16) < mDuty) ? 1 : 0;
        mBuzz = (mState == 3) ? 1 : (mState == 2) ? (((mPel / 4) % 2 == 0) ? 1 : 0) : 0;
    endtask

    task automatic checkOutput();
        checkVal("state", 32'(state), 32'(mState));
        checkVal("led_alerta", 32'(led_alerta), (mState >= 1) ? 32'd1 : 32'd0);
        checkVal("led_peligro", 32'(led_peligro), (mState >= 2) ? 32'd1 : 32'd0);
        checkVal("buzzer", 32'(buzzer), 32'(mBuzz));
        checkVal("fan_pwm", 32'(fan_pwm), 32'(mPwm));
    endtask

    // Inputs are driven away from the rising edge; outputs are checked on the falling edge.
    task automatic applyStimulus(input logic r, input logic [3:0] t, input logic g,
                                 input logic p, input logic a, input logic gr);
        reset = r; Temps = t; Gas = g; Peligro = p; Alerta = a; Greset = gr;
        @(posedge CLK);
        modelStep();
        @(negedge CLK);
        checkOutput();
    endtask

    task automatic countHigh(input logic [3:0] t, input logic p, output int cnt);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, t, 1'b0, p, 1'b0, 1'b0);
            if (fan_pwm === 1'b1) cnt++;
        end
    endtask

    task automatic idle(input int n, input logic [3:0] t, input logic p);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, t, 1'b0, p, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        mState = 0; mDuty = 0; mCyc = 0; mPel = 0; mPwm = 0; mBuzz = 0;

        // Reset held with Gas active, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("rst_state", 32'(state), 32'd0);
        checkVal("rst_buzzer", 32'(buzzer), 32'd0);
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("gas_after_rst", 32'(state), 32'd3);
        checkVal("gas_buzzer", 32'(buzzer), 32'd1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("greset_clear", 32'(state), 32'd0);

        // Normal PWM duties.
        idle(32, 4'd5, 1'b0);
        countHigh(4'd5, 1'b0, cnt);  checkVal("duty5", 32'(cnt), 32'd5);
        idle(32, 4'd0, 1'b0);
        countHigh(4'd0, 1'b0, cnt);  checkVal("duty0", 32'(cnt), 32'd0);
        idle(32, 4'd15, 1'b0);
        countHigh(4'd15, 1'b0, cnt); checkVal("duty15", 32'(cnt), 32'd15);

        // Alerta floor and latch, then Greset.
        idle(32, 4'd3, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(32, 4'd3, 1'b0);
        checkVal("alerta_latch", 32'(state), 32'd1);
        countHigh(4'd3, 1'b0, cnt);  checkVal("alerta_floor", 32'(cnt), 32'd12);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("alerta_cleared", 32'(state), 32'd0);
        idle(32, 4'd3, 1'b0);
        countHigh(4'd3, 1'b0, cnt);  checkVal("duty3_back", 32'(cnt), 32'd3);

        // Peligro blink: 4 high, 4 low, starting high on entry.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
            checkVal("blink", 32'(buzzer), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end
        checkVal("peligro_led", 32'(led_peligro), 32'd1);
        idle(16, 4'd1, 1'b1);
        countHigh(4'd1, 1'b1, cnt);  checkVal("peligro_full", 32'(cnt), 32'd16);

        // Priority and simultaneity.
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkVal("gas_over_alerta", 32'(state), 32'd3);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("greset_with_peligro", 32'(state), 32'd2);
        checkVal("emerg_to_pel_buzz", 32'(buzzer), 32'd1);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("pel_still_latched", 32'(state), 32'd2);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("pel_cleared", 32'(state), 32'd0);

        // Duty change mid-period: 2 -> 14 at phase 7.
        idle(32, 4'd2, 1'b0);
        for (int i = 0; i < 16 && (mCyc % 16) != 0; i++) applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("align_phase0", 32'(mCyc % 16), 32'd0);
        cnt = (fan_pwm === 1'b1) ? 1 : 0;
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b1, (i > 7) ? 4'd14 : 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
            if (fan_pwm === 1'b1) cnt++;
        end
        checkVal("midperiod_old", 32'(cnt), 32'd2);
        countHigh(4'd14, 1'b0, cnt); checkVal("midperiod_new", 32'(cnt), 32'd14);

        // Randomized traffic including occasional reset.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(99) != 0),
                          4'($urandom_range(15)),
                          ($urandom_range(29) == 0),
                          ($urandom_range(14) == 0),
                          ($urandom_range(9) == 0),
                          ($urandom_range(7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
